fsrc_tx_dac_buffer: RTL

// - Elastic buffer directly downstream of the TX FSRC stage. Absorbs the bursty

---
 rtl/fsrc_tx_buf_pkg.sv | 18 +
 rtl/fsrc_tx_buf_fifo.sv | 55 +++++
 rtl/fsrc_tx_dac_buffer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/fsrc_tx_buf_pkg.sv
// Shared types for the TX FSRC -> DAC elastic buffer.
package fsrc_tx_buf_pkg;

  // Buffer operating states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    RUN    = 2'd2,
    REFILL = 2'd3
  } state_t;

  // Data substituted on an underflowed DAC read
  typedef enum logic {
    FILL_ZERO = 1'b0,
    FILL_HOLD = 1'b1
  } fill_mode_t;

endpackage

// File: rtl/fsrc_tx_buf_fifo.sv
// Synchronous circular FIFO with flush; head is the word at the read pointer.
module fsrc_tx_buf_fifo #(
  parameter int unsigned DW = 64,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] head,
  output logic [AW:0]   level,
  output logic          full
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned LW    = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  // Guard against overrun/underrun even if the caller misbehaves
  assign pop_ok  = pop && (level != '0);
  assign push_ok = push && (!full || pop_ok);
  assign full    = (level == LW'(DEPTH));
  assign head    = mem[rd_ptr];

  // Pointer and occupancy tracking; flush empties the FIFO in one cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop_ok)      level <= level + LW'(1);
      else if (pop_ok && !push_ok) level <= level - LW'(1);
    end
  end

  // Storage array, write port only
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/fsrc_tx_dac_buffer.sv
// Elastic buffer between the TX FSRC stage and a DAC sink that pulls one word per dac_rd.
// Prefills to a threshold, then streams; on underflow substitutes fill data and refills.
module fsrc_tx_dac_buffer
  import fsrc_tx_buf_pkg::*;
#(
  parameter int unsigned NUM_OF_CHANNELS     = 4,
  parameter int unsigned SAMPLES_PER_CHANNEL = 1,
  parameter int unsigned SAMPLE_DATA_WIDTH   = 16,
  parameter int unsigned FIFO_ADDR_WIDTH     = 4,
  parameter int unsigned CNT_WIDTH           = 16,
  localparam int unsigned DW = NUM_OF_CHANNELS * SAMPLES_PER_CHANNEL * SAMPLE_DATA_WIDTH,
  localparam int unsigned LW = FIFO_ADDR_WIDTH + 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 enable,
  input  logic [LW-1:0]        start_threshold,
  input  logic                 fill_mode,
  input  logic                 clr_count,
  input  logic                 s_axis_valid,
  output logic                 s_axis_ready,
  input  logic [DW-1:0]        s_axis_data,
  input  logic                 dac_rd,
  output logic [DW-1:0]        dac_data,
  output logic                 dac_start,
  output logic                 underflow,
  output logic [CNT_WIDTH-1:0] underflow_count,
  output logic [LW-1:0]        level
);

  localparam int unsigned DEPTH = 2 ** FIFO_ADDR_WIDTH;

  state_t                 state_q;
  state_t                 state_d;
  logic [DW-1:0]          last_q;
  logic [DW-1:0]          last_d;
  logic [DW-1:0]          dac_data_d;
  logic [DW-1:0]          fill_word;
  logic [DW-1:0]          head;
  logic [CNT_WIDTH-1:0]   cnt_d;
  logic [LW-1:0]          thr;
  logic [LW-1:0]          level_d;
  logic                   dac_start_d;
  logic                   underflow_d;
  logic                   ready_d;
  logic                   push;
  logic                   pop;
  logic                   uf_event;
  logic                   full;

  assign push      = s_axis_valid && s_axis_ready && (!full || pop);
  assign fill_word = (fill_mode_t'(fill_mode) == FILL_HOLD) ? last_q : '0;

  // Clamp the prefill threshold into 1..DEPTH
  always_comb begin
    thr = start_threshold;
    if (start_threshold == '0)              thr = LW'(1);
    else if (start_threshold > LW'(DEPTH))  thr = LW'(DEPTH);
  end

  fsrc_tx_buf_fifo #(
    .DW (DW),
    .AW (FIFO_ADDR_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .flush   (!enable),
    .push    (push),
    .pop     (pop),
    .wr_data (s_axis_data),
    .head    (head),
    .level   (level),
    .full    (full)
  );

  // Next state, pop/underflow decisions and next values of the registered outputs
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    dac_data_d  = dac_data;
    dac_start_d = 1'b0;
    underflow_d = 1'b0;
    uf_event    = 1'b0;
    pop         = 1'b0;
    cnt_d       = underflow_count;
    level_d     = level;

    if (!enable) begin
      state_d    = IDLE;
      dac_data_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d    = FILL;
          dac_data_d = '0;
        end
        FILL: begin
          if (level >= thr) begin
            state_d     = RUN;
            dac_start_d = 1'b1;
          end
        end
        RUN: begin
          if (dac_rd) begin
            if (level != '0) begin
              pop        = 1'b1;
              dac_data_d = head;
              last_d     = head;
            end else begin
              // A same-cycle push does not bypass into an empty FIFO
              uf_event    = 1'b1;
              underflow_d = 1'b1;
              dac_data_d  = fill_word;
              state_d     = REFILL;
            end
          end
        end
        REFILL: begin
          if (dac_rd) dac_data_d = fill_word;
          if (level >= thr) begin
            state_d     = RUN;
            dac_start_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Clear wins over history but not over a coincident underflow
    if (clr_count)                                cnt_d = uf_event ? CNT_WIDTH'(1) : '0;
    else if (uf_event && (underflow_count != '1)) cnt_d = underflow_count + CNT_WIDTH'(1);

    if (!enable)             level_d = '0;
    else if (push && !pop)   level_d = level + LW'(1);
    else if (pop && !push)   level_d = level - LW'(1);

    ready_d = (state_d != IDLE) && (level_d < LW'(DEPTH));
  end

  // State and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= IDLE;
      last_q          <= '0;
      dac_data        <= '0;
      dac_start       <= 1'b0;
      underflow       <= 1'b0;
      underflow_count <= '0;
      s_axis_ready    <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_q          <= last_d;
      dac_data        <= dac_data_d;
      dac_start       <= dac_start_d;
      underflow       <= underflow_d;
      underflow_count <= cnt_d;
      s_axis_ready    <= ready_d;
    end
  end

endmodule
